// File: rtl/zbus_cycle_decoder_if.sv
// zbus_cycle_decoder_if: Z80 strobe/address/data inputs and decoded bus-cycle outputs.
interface zbus_cycle_decoder_if;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [15:0] a;
    logic [7:0]  d;
    logic        io_ready;
    logic        cyc_start, cyc_end;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic        wait_n, busy;
    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, a, d, io_ready,
        output cyc_start, cyc_end, cyc_type, cyc_addr, cyc_wdata, wait_n, busy
    );
    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, a, d, io_ready,
        input  cyc_start, cyc_end, cyc_type, cyc_addr, cyc_wdata, wait_n, busy
    );
endinterface

// File: rtl/zbus_cycle_decoder.sv
// zbus_cycle_decoder: synchronizes and deglitches Z80 strobes, classifies bus cycles, stretches I/O with wait_n.
// Optional `ZBUS_WR_FIX_EN: classify I/O writes as iorq & ~rd & ~m1, ignoring wr_n on I/O.
module zbus_cycle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2,
    parameter int WAIT_CYCLES = 4
) (
    input logic fclk,
    input logic rst,
    zbus_cycle_decoder_if.slave bus
);
    typedef enum logic [1:0] {ARMWAIT, IDLE, ACTIVE, WAIT} state_t;
    state_t state_q, state_d;
    logic [5:0] raw;
    logic [SYNC_STAGES-1:0][5:0]  sync_q;
    logic [SYNC_STAGES-1:0][15:0] a_q;
    logic [SYNC_STAGES-1:0][7:0]  d_q;
    logic [5:0][FILTER-1:0] win_q, win_d;
    logic [5:0] filt_q, filt_d;
    logic mreq, iorq, rd, wr, m1, rfsh, io_wr, bus_idle, io_cls;
    logic [2:0] cls, type_q, type_d;
    logic [3:0] cnt_q, cnt_d;
    logic start_q, start_d, end_q, end_d, wait_n_q, wait_n_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    assign raw = {bus.rfsh_n, bus.m1_n, bus.wr_n, bus.rd_n, bus.iorq_n, bus.mreq_n};
    // pipeline resets to "asserted" so ARMWAIT only exits once the real pins are seen idle
    always_comb
        for (int i = 0; i < 6; i++) begin
            win_d[i]  = FILTER'({win_q[i], sync_q[SYNC_STAGES-1][i]});
            filt_d[i] = &win_d[i] ? 1'b1 : ~|win_d[i] ? 1'b0 : filt_q[i];
        end
    assign {rfsh, m1, wr, rd, iorq, mreq} = ~filt_q;
`ifdef ZBUS_WR_FIX_EN
    assign io_wr = iorq & ~rd & ~m1;
`else
    assign io_wr = iorq & wr;
`endif
    assign bus_idle = ~mreq & ~iorq;
    assign cls = (m1 & iorq)       ? 3'd7 :
                 (m1 & mreq & rd)  ? 3'd1 :
                 (rfsh & mreq)     ? 3'd6 :
                 (mreq & rd)       ? 3'd2 :
                 (mreq & wr)       ? 3'd3 :
                 (iorq & rd)       ? 3'd4 :
                 io_wr             ? 3'd5 : 3'd0;
    assign io_cls = (cls == 3'd4) || (cls == 3'd5) || (cls == 3'd7);
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        end_d    = 1'b0;
        wait_n_d = 1'b1;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ARMWAIT: state_d = bus_idle ? IDLE : ARMWAIT;
            IDLE: if (cls != 3'd0) begin
                start_d = 1'b1;
                type_d  = cls;
                addr_d  = a_q[SYNC_STAGES-1];
                wdata_d = (cls == 3'd3 || cls == 3'd5) ? d_q[SYNC_STAGES-1] : wdata_q;
                if (io_cls && WAIT_CYCLES > 0) begin
                    state_d  = WAIT;
                    wait_n_d = 1'b0;
                    cnt_d    = 4'(WAIT_CYCLES);
                end else
                    state_d = ACTIVE;
            end
            WAIT: if (bus_idle) begin
                state_d = IDLE;
                end_d   = 1'b1;
            end else if (bus.io_ready || cnt_q == 4'd1)
                state_d = ACTIVE;
            else begin
                cnt_d    = cnt_q - 4'd1;
                wait_n_d = 1'b0;
            end
            default: if (bus_idle) begin
                state_d = IDLE;
                end_d   = 1'b1;
            end
        endcase
    end
    always_ff @(posedge fclk) begin
        if (rst) begin
            sync_q   <= '0;
            win_q    <= '0;
            filt_q   <= '0;
            state_q  <= ARMWAIT;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            wait_n_q <= 1'b1;
            type_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            win_q    <= win_d;
            filt_q   <= filt_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            end_q    <= end_d;
            wait_n_q <= wait_n_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
        a_q <= {a_q[SYNC_STAGES-2:0], bus.a};
        d_q <= {d_q[SYNC_STAGES-2:0], bus.d};
    end
    assign bus.cyc_start = start_q;
    assign bus.cyc_end   = end_q;
    assign bus.cyc_type  = type_q;
    assign bus.cyc_addr  = addr_q;
    assign bus.cyc_wdata = wdata_q;
    assign bus.wait_n    = wait_n_q;
    assign bus.busy      = (state_q == ACTIVE) || (state_q == WAIT);
endmodule

// File: tb/tb_zbus_cycle_decoder.sv
// tb_zbus_cycle_decoder: directed and randomized bus cycles checked against a rule-table model.
module tb_zbus_cycle_decoder;
    localparam int W = 4;
    localparam int LAT = 5;
    // strobe bit order {rfsh, m1, wr, rd, iorq, mreq}, 1 = asserted
    localparam logic [5:0] REQ [7] = '{6'b010010, 6'b010101, 6'b100001, 6'b000101, 6'b001001, 6'b000110,
`ifdef ZBUS_WR_FIX_EN
                                       6'b000010};
    localparam logic [5:0] FORB [7] = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b010100};
`else
                                       6'b001010};
    localparam logic [5:0] FORB [7] = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
`endif
    localparam logic [2:0] TYP [7] = '{3'd7, 3'd1, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5};
    logic fclk = 1'b0;
    logic rst;
    int passes = 0, fails = 0, total = 0;
    logic [7:0] exp_wdata;
    zbus_cycle_decoder_if bus ();
    zbus_cycle_decoder dut (.fclk(fclk), .rst(rst), .bus(bus));
    always #5 fclk = ~fclk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    function automatic logic [2:0] model_type(input logic [5:0] act);
        for (int r = 0; r < 7; r++)
            if ((act & REQ[r]) == REQ[r] && (act & FORB[r]) == 6'b0) return TYP[r];
        return 3'd0;
    endfunction
    task automatic tick();
        @(posedge fclk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [5:0] act);
        {bus.rfsh_n, bus.m1_n, bus.wr_n, bus.rd_n, bus.iorq_n, bus.mreq_n} = ~act;
    endtask
    task automatic wait_for(input bit want_end, output int n, output int lows);
        lows = 0;
        for (n = 1; n <= 15; n++) begin
            tick();
            lows += int'(!bus.wait_n);
            if (want_end ? bus.cyc_end : bus.cyc_start) break;
        end
    endtask
    task automatic quiet(input string tag, input int cycles);
        int s = 0, e = 0, l = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            s += int'(bus.cyc_start);
            e += int'(bus.cyc_end);
            l += int'(!bus.wait_n);
        end
        chk({tag, "_nostart"}, s, 0);
        chk({tag, "_noend"}, e, 0);
        chk({tag, "_nowait"}, l, 0);
    endtask
    task automatic txn(input string tag, input logic [5:0] act, input logic [15:0] addr,
                       input logic [7:0] data, input int hold, input int rdy_at);
        logic [2:0] et;
        int n, lows, l2, exp_lows;
        et = model_type(act);
        bus.a = addr;
        bus.d = data;
        drive(act);
        if (et == 3'd0) begin
            quiet(tag, 12);
            drive(6'b0);
            repeat (8) tick();
            return;
        end
        wait_for(1'b0, n, l2);
        chk({tag, "_start_lat"}, n, LAT);
        chk({tag, "_prestart_wait"}, l2 - int'(!bus.wait_n), 0);
        if (et == 3'd3 || et == 3'd5) exp_wdata = data;
        chk({tag, "_type"}, bus.cyc_type, et);
        chk({tag, "_addr"}, bus.cyc_addr, addr);
        chk({tag, "_wdata"}, bus.cyc_wdata, exp_wdata);
        chk({tag, "_busy"}, bus.busy, 1);
        exp_lows = !(et == 3'd4 || et == 3'd5 || et == 3'd7) ? 0 :
                   (rdy_at >= 1 && rdy_at <= W && rdy_at <= hold) ? rdy_at : W;
        lows = int'(!bus.wait_n);
        for (int j = 1; j <= hold; j++) begin
            bus.io_ready = (j == rdy_at);
            tick();
            lows += int'(!bus.wait_n);
        end
        bus.io_ready = 1'b0;
        drive(6'b0);
        wait_for(1'b1, n, l2);
        chk({tag, "_end_lat"}, n, LAT);
        chk({tag, "_wait_lows"}, lows + l2, exp_lows);
        chk({tag, "_end_busy"}, bus.busy, 0);
        chk({tag, "_end_wait_n"}, bus.wait_n, 1);
        chk({tag, "_type_held"}, bus.cyc_type, et);
        repeat (3) tick();
    endtask
    initial begin
        int n, l;
        rst = 1'b1;
        exp_wdata = 8'h00;
        bus.io_ready = 1'b0;
        bus.a = 16'h0;
        bus.d = 8'h0;
        drive(6'b000101);
        repeat (3) tick();
        chk("rst_start", bus.cyc_start, 0);
        chk("rst_end", bus.cyc_end, 0);
        chk("rst_type", bus.cyc_type, 0);
        chk("rst_addr", bus.cyc_addr, 0);
        chk("rst_wdata", bus.cyc_wdata, 0);
        chk("rst_wait_n", bus.wait_n, 1);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        quiet("armwait", 12);
        drive(6'b0);
        repeat (5) tick();
        txn("fetch", 6'b010101, 16'h0038, 8'h00, 3, 0);
        bus.a = 16'h5B00;
        bus.d = 8'h00;
        drive(6'b000001);
        repeat (2) tick();
        bus.d = 8'hA5;
        drive(6'b001001);
        wait_for(1'b0, n, l);
        chk("memwr_start_lat", n, LAT);
        chk("memwr_type", bus.cyc_type, 3);
        chk("memwr_addr", bus.cyc_addr, 16'h5B00);
        chk("memwr_wdata", bus.cyc_wdata, 8'hA5);
        exp_wdata = 8'hA5;
        repeat (3) tick();
        drive(6'b0);
        wait_for(1'b1, n, l);
        chk("memwr_end_lat", n, LAT);
        repeat (3) tick();
        txn("ioread_full", 6'b000110, 16'h00FE, 8'h00, 8, 0);
        txn("ioread_rdy2", 6'b000110, 16'h00FE, 8'h00, 8, 2);
        txn("ioread_rdy1", 6'b000110, 16'h00FE, 8'h00, 8, 1);
        drive(6'b000100);
        tick();
        drive(6'b000110);
        tick();
        drive(6'b000100);
        quiet("glitch", 12);
        drive(6'b0);
        repeat (6) tick();
        bus.a = 16'h00FE;
        drive(6'b000110);
        wait_for(1'b0, n, l);
        chk("rstwait_start_lat", n, LAT);
        tick();
        chk("rstwait_in_wait", bus.wait_n, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_wdata = 8'h00;
        chk("rstwait_wait_n", bus.wait_n, 1);
        chk("rstwait_busy", bus.busy, 0);
        chk("rstwait_end", bus.cyc_end, 0);
        quiet("rstwait_hold", 10);
        drive(6'b0);
        repeat (6) tick();
        txn("iowr_nowr", 6'b000010, 16'h10FE, 8'h5A, 6, 0);
        txn("intack", 6'b010010, 16'h00FF, 8'h00, 2, 0);
        bus.a = 16'h1111;
        drive(6'b000101);
        wait_for(1'b0, n, l);
        chk("rdrise_type", bus.cyc_type, 2);
        drive(6'b000001);
        quiet("rdrise_hold", 10);
        chk("rdrise_busy", bus.busy, 1);
        drive(6'b0);
        wait_for(1'b1, n, l);
        chk("rdrise_end_lat", n, LAT);
        repeat (3) tick();
        for (int k = 0; k < 30; k++)
            txn($sformatf("rand%0d", k), 6'($urandom_range(0, 63)), 16'($urandom), 8'($urandom),
                $urandom_range(1, 8), $urandom_range(0, 5));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
